truth_table_sweeper: RTL and testbench
======================================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter: EXPECTED, 16'hF81A, golden truth table of the downstream 4-input SOP stage; bit i is the required f_in for vector i = {a,b,c,d}.
REQ-002 Parameter: SETTLE, 1, number of cycles each vector is held before sampling; legal range 1..15.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port: start  input  1  request one full sweep; sampled only in IDLE or DONE.
REQ-006 Port: f_in  input  1  output of the downstream SOP stage under test.
REQ-007 Port: a, b, c, d  output  1 each  registered stimulus to the downstream stage; {a,b,c,d} = current vector index.
REQ-008 Port: busy  output  1  high while a sweep is in progress.
REQ-009 Port: done  output  1  high from sweep completion until the next accepted start or reset.
REQ-010 Port: table_out  output  16  captured truth table; bit i = f_in sampled for vector i.
REQ-011 Port: err_count  output  5  number of vectors where f_in != EXPECTED[i], 0..16.
REQ-012 Port: err_valid  output  1  at least one mismatch recorded this sweep.
REQ-013 Port: first_err  output  4  index of the lowest mismatching vector; 0 when err_valid=0.
REQ-014 Port: pass  output  1  done && err_count==0.

Function
REQ-015 FSM states: IDLE, APPLY, SAMPLE, DONE; one-hot or binary at implementer's choice.
REQ-016 IDLE/DONE + start=1: next state APPLY, idx=0, wait counter=0, table_out=0, err_count=0, err_valid=0, first_err=0, done=0, busy=1.
REQ-017 APPLY: {a,b,c,d} driven from idx; wait counter increments each cycle; after SETTLE cycles in APPLY, go to SAMPLE.
REQ-018 SAMPLE: exactly one cycle; at its closing edge, table_out[idx] <= f_in; if f_in != EXPECTED[idx], err_count increments, and if err_valid was 0, first_err <= idx and err_valid <= 1.
REQ-019 SAMPLE with idx<15: idx increments, wait counter clears, go to APPLY.
REQ-020 SAMPLE with idx==15: go to DONE; busy=0, done=1; idx does not wrap and {a,b,c,d} holds 4'hF.
REQ-021 Each vector occupies SETTLE+1 cycles; done rises 16*(SETTLE+1) cycles after the edge that accepts start (32 cycles at SETTLE=1).
REQ-022 start while busy is ignored; the sweep in progress is unaffected.
REQ-023 start in DONE restarts immediately per REQ-016; previous results clear at that same edge.
REQ-024 f_in is sampled only in SAMPLE; its value in other states has no effect.
REQ-025 err_count saturation is not required (maximum 16 fits in 5 bits).
REQ-026 All outputs are registered; no combinational path from start or f_in to any output.

Reset
REQ-027 rst_n=0 at a rising edge forces IDLE, idx=0, a=b=c=d=0, busy=0, done=0, pass=0, table_out=0, err_count=0, err_valid=0, first_err=0.
REQ-028 Reset asserted mid-sweep aborts the sweep with no partial done; start held through reset release is accepted on the first edge with rst_n=1.

Structure
REQ-029 Shared package holds the FSM state type, NUM_VECTORS=16, and the default golden constant 16'hF81A for the SOP function.
REQ-030 Single module; no sub-module. The SOP stage is instantiated only in the bench, with f_in tied to its out.

Verification
REQ-031 Reset, then start pulse with correct SOP stage attached, SETTLE=1 -> done at cycle 32, table_out=16'hF81A, err_count=0, pass=1.
REQ-032 f_in forced to 0 -> table_out=16'h0000, err_count=8, first_err=1, err_valid=1, pass=0.
REQ-033 SOP stage with in[3] stuck at 0 -> err_count=4, first_err=12, table_out=16'h081A.
REQ-034 start re-pulsed at cycles 5 and 20 of a sweep -> no effect; done still at cycle 32; then start in DONE -> outputs clear, new sweep completes after 32 more cycles.
REQ-035 rst_n low at cycle 10 of a sweep -> next edge all outputs at reset values, busy=0, done never asserted.
REQ-036 SETTLE=3 -> each vector held 4 cycles, done at cycle 64; monitor confirms {a,b,c,d} steps 0..15 in order.

Source files
------------

// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
package truth_table_sweeper_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_VECTORS  = 16;
  localparam logic [15:0] GOLDEN_TABLE = 16'hF81A;

endpackage

// File: rtl/truth_table_sweeper.sv
// Walks all 16 input vectors of a 4-input SOP stage, captures its response
// and compares it against a golden truth table.
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter logic [15:0] EXPECTED = GOLDEN_TABLE,
  parameter int unsigned SETTLE   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        f_in,
  output logic        a,
  output logic        b,
  output logic        c,
  output logic        d,
  output logic        busy,
  output logic        done,
  output logic [15:0] table_out,
  output logic [4:0]  err_count,
  output logic        err_valid,
  output logic [3:0]  first_err,
  output logic        pass
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);
  localparam logic [3:0] LAST_IDX  = 4'(NUM_VECTORS - 1);

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic [3:0] wcnt;
  logic       mismatch;
  logic [4:0] err_nxt;

  assign {a, b, c, d} = idx;
  assign mismatch     = (f_in != EXPECTED[idx]);
  assign err_nxt      = err_count + 5'(mismatch);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = APPLY;
      APPLY:      if (wcnt == SETTLE_M1) state_nxt = SAMPLE;
      SAMPLE:     state_nxt = (idx == LAST_IDX) ? DONE : APPLY;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      wcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      table_out <= '0;
      err_count <= '0;
      err_valid <= 1'b0;
      first_err <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            idx       <= '0;
            wcnt      <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            table_out <= '0;
            err_count <= '0;
            err_valid <= 1'b0;
            first_err <= '0;
          end
        end
        APPLY: wcnt <= wcnt + 4'd1;
        SAMPLE: begin
          table_out[idx] <= f_in;
          err_count      <= err_nxt;
          if (mismatch && !err_valid) begin
            first_err <= idx;
            err_valid <= 1'b1;
          end
          if (idx == LAST_IDX) begin
            // pass is registered from the final count so it rises with done
            busy <= 1'b0;
            done <= 1'b1;
            pass <= (err_nxt == 5'd0);
          end else begin
            idx  <= idx + 4'd1;
            wcnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: SOP stage modelled in the bench, table-driven sweeps plus
// hand-written restart, reset-abort and long-settle sequences.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, start3;
  logic        f_in, f_in3;
  logic        a, b, c, d, a3, b3, c3, d3;
  logic        busy, done, err_valid, pass;
  logic        busy3, done3, err_valid3, pass3;
  logic [15:0] table_out, table_out3;
  logic [4:0]  err_count, err_count3;
  logic [3:0]  first_err, first_err3;
  int          mode;  // 0 good SOP, 1 f_in=0, 2 term a&b stuck at 0, 3 f_in=1
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  // Reference SOP: f = ~a~bd + ~ab~c~d + a~bcd + ab
  function automatic logic sop(input logic va, vb, vc, vd, input logic kill_ab);
    logic [3:0] term;
    term[0] = ~va & ~vb & vd;
    term[1] = ~va & vb & ~vc & ~vd;
    term[2] = va & ~vb & vc & vd;
    term[3] = va & vb & ~kill_ab;
    return |term;
  endfunction

  always_comb begin
    f_in = 1'b0;
    case (mode)
      1:       f_in = 1'b0;
      3:       f_in = 1'b1;
      2:       f_in = sop(a, b, c, d, 1'b1);
      default: f_in = sop(a, b, c, d, 1'b0);
    endcase
  end

  assign f_in3 = sop(a3, b3, c3, d3, 1'b0);

  truth_table_sweeper #(.EXPECTED(16'hF81A), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in),
    .a(a), .b(b), .c(c), .d(d), .busy(busy), .done(done),
    .table_out(table_out), .err_count(err_count), .err_valid(err_valid),
    .first_err(first_err), .pass(pass)
  );

  truth_table_sweeper #(.EXPECTED(16'hF81A), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .f_in(f_in3),
    .a(a3), .b(b3), .c(c3), .d(d3), .busy(busy3), .done(done3),
    .table_out(table_out3), .err_count(err_count3), .err_valid(err_valid3),
    .first_err(first_err3), .pass(pass3)
  );

  typedef struct {
    int          mode;
    logic [15:0] tbl;
    logic [4:0]  errs;
    logic [3:0]  first;
    logic        valid;
    logic        pass;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Pulse start for one edge and check the outputs cleared at that edge.
  task automatic accept_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_clear", {table_out, 11'd0, err_count, err_valid, done, pass},
        32'd0);
  endtask

  // Count edges after acceptance until done; optional re-pulses of start.
  task automatic wait_done(input int limit, input logic repulse, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin
      start = repulse && (cyc == 4 || cyc == 19);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic check_reset_state(input string name);
    chk(name, {table_out, err_count, err_valid, first_err, busy, done, pass,
               a, b, c, d}, 32'd0);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{0, 16'hF81A, 5'd0, 4'd0,  1'b0, 1'b1};
    vecs[1] = '{1, 16'h0000, 5'd8, 4'd1,  1'b1, 1'b0};
    vecs[2] = '{2, 16'h081A, 5'd4, 4'd12, 1'b1, 1'b0};
    vecs[3] = '{3, 16'hFFFF, 5'd8, 4'd0,  1'b1, 1'b0};

    mode = 0; start = 1'b0; start3 = 1'b0; rst_n = 1'b0;
    @(negedge clk); @(posedge clk); @(posedge clk); #1;
    check_reset_state("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_start", {30'd0, busy, done}, 32'd0);

    // Back-to-back sweeps: each start after the first lands in DONE.
    for (int i = 0; i < 4; i++) begin
      mode = vecs[i].mode;
      accept_start();
      wait_done(200, 1'b0, cyc);
      chk($sformatf("v%0d_latency", i), 32'(cyc), 32'd32);
      chk($sformatf("v%0d_table", i), 32'(table_out), 32'(vecs[i].tbl));
      chk($sformatf("v%0d_errs", i), 32'(err_count), 32'(vecs[i].errs));
      chk($sformatf("v%0d_first", i), 32'(first_err), 32'(vecs[i].first));
      chk($sformatf("v%0d_valid", i), 32'(err_valid), 32'(vecs[i].valid));
      chk($sformatf("v%0d_pass", i), 32'(pass), 32'(vecs[i].pass));
      chk($sformatf("v%0d_busy_abcd", i), {27'd0, busy, a, b, c, d}, 32'hF);
    end

    // Re-pulsing start mid-sweep must not disturb the sweep.
    mode = 0;
    accept_start();
    wait_done(200, 1'b1, cyc);
    chk("repulse_latency", 32'(cyc), 32'd32);
    chk("repulse_table", 32'(table_out), 32'hF81A);
    chk("repulse_pass", 32'(pass), 32'd1);
    // Restart from DONE clears results, then runs another full sweep.
    accept_start();
    wait_done(200, 1'b0, cyc);
    chk("restart_latency", 32'(cyc), 32'd32);
    chk("restart_pass", {err_count, 26'd0, pass}, 32'd1);

    // Reset in the middle of a sweep aborts it.
    accept_start();
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midreset");
    rst_n = 1'b1;
    cyc = 0;
    while (!done && cyc < 40) begin @(posedge clk); #1; cyc++; end
    chk("midreset_no_done", 32'(done), 32'd0);
    chk("midreset_idle", 32'(busy), 32'd0);

    // start held through reset release is taken on the first free edge.
    rst_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    chk("held_in_reset", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("held_accept", 32'(busy), 32'd1);
    wait_done(200, 1'b0, cyc);
    chk("held_latency", 32'(cyc), 32'd32);

    // SETTLE=3 instance: vector index must step every 4 cycles.
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    cyc = 0;
    chk("s3_step", {28'd0, a3, b3, c3, d3}, 32'd0);
    while (!done3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc < 64) chk($sformatf("s3_step%0d", cyc), {28'd0, a3, b3, c3, d3}, 32'(cyc / 4));
    end
    chk("s3_latency", 32'(cyc), 32'd64);
    chk("s3_table", 32'(table_out3), 32'hF81A);
    chk("s3_pass", {err_count3, 26'd0, pass3}, 32'd1);
    chk("s3_abcd_hold", {28'd0, a3, b3, c3, d3}, 32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
